// File: rtl/cone_sched_pkg.sv
// ============================================================================
// Module  : cone_sched_pkg
// Brief   : Shared types, constants and the round-robin pick helper used by
//           the cone sprite ROM scheduler and its arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cone_sched_pkg;

  // Burst sequencer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Chroma-key green treated as transparent when keying is enabled
  localparam logic [23:0] CHROMA_KEY = 24'h00FF00;

  // Widest request vector the pick helper accepts
  localparam int MAX_REQ = 32;

  // First set bit of req scanning upward from ptr, modulo n.
  // Returns 0 when no bit is set; callers qualify with an any-request flag.
  function automatic int next_rr(input int ptr, input logic [MAX_REQ-1:0] req, input int n);
    int   idx;
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cone_rr_arbiter.sv
// ============================================================================
// Module  : cone_rr_arbiter
// Brief   : Combinational round-robin pick. Scans req upward from rr_ptr and
//           returns a one-hot grant plus the winner's index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cone_rr_arbiter
  import cone_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_req
);

  int w_win;

  // Pick the winner and expand it to a one-hot grant
  always_comb begin
    any_req   = |req;
    w_win     = next_rr(int'(rr_ptr), MAX_REQ'(req), N_REQ);
    grant_idx = ID_W'(w_win);
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = any_req && (w_win == i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cone_rom_scheduler.sv
// ============================================================================
// Module  : cone_rom_scheduler
// Brief   : Shares one cone sprite ROM read port among N_REQ sprite drawers.
//           Grants row bursts round-robin, walks consecutive ROM addresses
//           (wrapping at DEPTH) and returns pixels tagged with the requester
//           id, aligned to the ROM read latency.
//           Optional macro CONE_SCHED_CHROMA_EN: pix_opaque drops for the
//           chroma-key green; otherwise pix_opaque follows pix_valid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cone_rom_scheduler
  import cone_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 2160,
  parameter int LEN_W   = 6,
  parameter int ROM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          ack,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [23:0]               rom_data,
  output logic                      pix_valid,
  output logic [23:0]               pix_data,
  output logic [$clog2(N_REQ)-1:0]  pix_id,
  output logic                      pix_last,
  output logic                      pix_opaque,
  output logic                      busy
);

  localparam int                 C_ID_W      = $clog2(N_REQ);
  localparam logic [C_ID_W-1:0]  C_ID_LAST   = C_ID_W'(N_REQ - 1);
  localparam logic [ADDR_W-1:0]  C_ADDR_LAST = ADDR_W'(DEPTH - 1);

  // Tag travelling alongside each issued address until its data returns
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [C_ID_W-1:0] id;
  } pix_tag_t;

  state_t              state_q,  state_d;
  logic [C_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [LEN_W-1:0]    rem_q,    rem_d;
  logic [C_ID_W-1:0]   id_q,     id_d;
  pix_tag_t            pipe_q [ROM_LAT];
  pix_tag_t            pipe_d [ROM_LAT];

  logic [N_REQ-1:0]    w_grant;
  logic [C_ID_W-1:0]   w_grant_idx;
  logic                w_any;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [N_REQ-1:0]    w_ack;
  logic                w_issue;
  logic                w_issue_last;

  cone_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (C_ID_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_req   (w_any)
  );

  assign w_sel_addr = req_addr[int'(w_grant_idx) * ADDR_W +: ADDR_W];
  assign w_sel_len  = req_len[int'(w_grant_idx) * LEN_W +: LEN_W];

  // Next-state: grant in IDLE, then walk base..base+len-1 in BURST.
  // rem_q counts addresses still to issue after the current one, so the
  // cycle with rem_q == 0 issues the final address and returns to IDLE.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    id_d         = id_q;
    w_ack        = '0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          w_ack    = w_grant;
          rr_ptr_d = (w_grant_idx == C_ID_LAST) ? '0 : w_grant_idx + C_ID_W'(1);
          // A zero-length request is acknowledged but issues nothing
          if (w_sel_len != '0) begin
            state_d = BURST;
            addr_d  = w_sel_addr;
            rem_d   = w_sel_len - LEN_W'(1);
            id_d    = w_grant_idx;
          end
        end
      end
      BURST: begin
        w_issue      = 1'b1;
        w_issue_last = (rem_q == '0);
        if (rem_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d = (addr_q == C_ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return-tag shift register: stage 0 launched with each issued address
  always_comb begin
    pipe_d[0].valid = w_issue;
    pipe_d[0].last  = w_issue_last;
    pipe_d[0].id    = w_issue ? id_q : '0;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State, burst counters and return pipeline registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      id_q     <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      id_q     <= id_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // ack is combinational from the arbiter; hold it low while in reset
  assign ack       = w_ack & {N_REQ{Reset_n}};
  assign rom_addr  = addr_q;
  assign busy      = (state_q == BURST);
  assign pix_valid = pipe_q[ROM_LAT-1].valid;
  assign pix_id    = pipe_q[ROM_LAT-1].id;
  assign pix_last  = pipe_q[ROM_LAT-1].last;
  assign pix_data  = pix_valid ? rom_data : '0;

`ifdef CONE_SCHED_CHROMA_EN
  assign pix_opaque = pix_valid && (rom_data != CHROMA_KEY);
`else
  assign pix_opaque = pix_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cone_rom_scheduler.sv
// ============================================================================
// Module  : tb_cone_rom_scheduler
// Brief   : Self-checking bench for cone_rom_scheduler: cycle model with a
//           pixel scoreboard, a vector table of single bursts and hand
//           sequences for round-robin, zero-length and mid-burst reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cone_rom_scheduler;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 2160;
  localparam int LEN_W   = 6;
  localparam int ROM_LAT = 1;
`ifdef CONE_SCHED_CHROMA_EN
  localparam bit KEY_OPAQUE = 1'b0;
`else
  localparam bit KEY_OPAQUE = 1'b1;
`endif

  logic                    Clk      = 1'b0;
  logic                    Reset_n  = 1'b1;
  logic [N_REQ-1:0]        req      = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*LEN_W-1:0]  req_len  = '0;
  logic [N_REQ-1:0]        ack;
  logic [ADDR_W-1:0]       rom_addr;
  logic [23:0]             rom_data = '0;
  logic                    pix_valid;
  logic [23:0]             pix_data;
  logic [1:0]              pix_id;
  logic                    pix_last;
  logic                    pix_opaque;
  logic                    busy;

  cone_rom_scheduler #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .req_len(req_len),
    .ack(ack), .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_id(pix_id), .pix_last(pix_last), .pix_opaque(pix_opaque),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [23:0] rom_fn(input logic [11:0] a);
    if (a == 12'd500) return 24'h00FF00;
    if (a == 12'd501) return 24'hFF512F;
    return {a, ~a};
  endfunction

  function automatic logic exp_op(input logic [23:0] d);
    return (d != 24'h00FF00) || KEY_OPAQUE;
  endfunction

  // ROM with one cycle of read latency
  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- cycle model + scoreboard ----------------
  typedef struct {
    logic [1:0]  id;
    logic        last;
    logic [23:0] data;
    logic        opaque;
    int          due;
  } pix_exp_t;

  pix_exp_t    pq[$];
  int          ack_log_id[$];
  int          ack_log_cyc[$];
  logic [49:0] op_log[$];
  int          m_rem = 0, m_k = 0, m_len = 0, m_ptr = 0;
  logic [11:0] m_base = '0;
  logic [1:0]  m_id = '0;
  int          ack_cnt = 0, pix_cnt = 0, last_cnt = 0, busy_cnt = 0;
  logic [3:0]  last_ack = '0;
  int          burst_first = 0, burst_last = 0;
  pix_exp_t    me;
  logic [3:0]  e_ack;
  logic [11:0] ea;
  int          w;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      m_rem = 0; m_ptr = 0; m_k = 0;
      pq.delete();
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_rom_addr", rom_addr, 0);
    end else begin
      // return side
      if (pix_valid) begin
        pix_cnt++;
        if (pix_last) last_cnt++;
        op_log.push_back({pix_data, pix_opaque, 25'd0});
        if (pq.size() == 0) begin
          chk("stray_pix", 1, 0);
        end else begin
          me = pq.pop_front();
          chk("pix_due", cyc, me.due);
          chk("pix_id", pix_id, me.id);
          chk("pix_last", pix_last, me.last);
          chk("pix_data", pix_data, me.data);
          chk("pix_opaque", pix_opaque, me.opaque);
        end
      end else if (pq.size() != 0 && pq[0].due <= cyc) begin
        me = pq.pop_front();
        chk("missing_pix", 0, 1);
      end
      // request side
      e_ack = '0;
      if (m_rem != 0) begin
        chk("busy", busy, 1);
        busy_cnt++;
        ea = 12'((int'(m_base) + m_k) % DEPTH);
        chk("rom_addr", rom_addr, ea);
        if (m_k == 0) burst_first = int'(rom_addr);
        burst_last = int'(rom_addr);
        me.id = m_id; me.last = (m_k == m_len - 1); me.data = rom_fn(ea);
        me.opaque = exp_op(me.data); me.due = cyc + ROM_LAT;
        pq.push_back(me);
        m_k++; m_rem--;
      end else begin
        chk("busy", busy, 0);
        if (req != 0) begin
          w = -1;
          for (int i = 0; i < N_REQ; i++)
            if (w < 0 && req[(m_ptr + i) % N_REQ]) w = (m_ptr + i) % N_REQ;
          e_ack[w] = 1'b1;
          m_ptr  = (w + 1) % N_REQ;
          m_id   = 2'(w);
          m_base = req_addr[w*ADDR_W +: ADDR_W];
          m_len  = int'(req_len[w*LEN_W +: LEN_W]);
          m_rem  = m_len;
          m_k    = 0;
        end
      end
      chk("ack", ack, e_ack);
      if (ack != 0) begin
        ack_cnt++;
        last_ack = ack;
        for (int i = 0; i < N_REQ; i++) if (ack[i]) ack_log_id.push_back(i);
        ack_log_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic set_req(input int id, input int addr, input int len);
    req_addr[id*ADDR_W +: ADDR_W] = 12'(addr);
    req_len[id*LEN_W +: LEN_W]    = 6'(len);
    req[id]                       = 1'b1;
  endtask

  task automatic wait_acks(input int n, input string name);
    int target;
    int t;
    target = ack_cnt + n;
    t = 0;
    while (ack_cnt < target && t < 80) begin
      @(negedge Clk); #1;
      t++;
    end
    chk({name, "_ack_wait"}, ack_cnt >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(negedge Clk); #1;
      t++;
    end while ((busy || m_rem != 0 || pq.size() != 0) && t < 150);
    chk({name, "_idle_wait"}, (busy || m_rem != 0 || pq.size() != 0), 0);
  endtask

  typedef struct {
    int         id;
    int         addr;
    int         len;
    logic [3:0] exp_ack;
    int         exp_first;
    int         exp_last;
    int         exp_npix;
  } vec_t;

  vec_t tbl[7];
  int   lb, p0, l0, b0;

  initial begin
    tbl[0] = '{1, 100,  4,  4'b0010, 100,  103,  4};
    tbl[1] = '{0, 2158, 4,  4'b0001, 2158, 1,    4};
    tbl[2] = '{2, 9,    0,  4'b0100, 0,    0,    0};
    tbl[3] = '{3, 2159, 3,  4'b1000, 2159, 1,    3};
    tbl[4] = '{3, 1000, 63, 4'b1000, 1000, 1062, 63};
    tbl[5] = '{0, 500,  2,  4'b0001, 500,  501,  2};
    tbl[6] = '{2, 2000, 1,  4'b0100, 2000, 2000, 1};

    // reset state
    #1 Reset_n = 1'b0;
    #2;
    chk("init_ack", ack, 0);
    chk("init_rom_addr", rom_addr, 0);
    chk("init_busy", busy, 0);
    chk("init_pix", {pix_valid, pix_data, pix_id, pix_last, pix_opaque}, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    tick();

    // all four requesters held, len=2: order 0,1,2,3,0.. spaced 3 cycles
    for (int i = 0; i < N_REQ; i++) set_req(i, 16 * i, 2);
    lb = ack_log_id.size();
    wait_acks(8, "rr4");
    tick();
    req = '0;
    wait_idle("rr4");
    if (ack_log_id.size() >= lb + 8) begin
      for (int i = 0; i < 8; i++) chk("rr4_order", ack_log_id[lb+i], i % 4);
      for (int i = 1; i < 8; i++) chk("rr4_spacing", ack_log_cyc[lb+i] - ack_log_cyc[lb+i-1], 3);
    end

    // len=0 on req[2] with req[3] waiting: ack[2] then ack[3] next cycle
    tick();
    set_req(2, 7, 0);
    set_req(3, 40, 2);
    lb = ack_log_id.size();
    wait_acks(1, "len0_a");
    chk("len0_rom_addr", rom_addr, 49);
    chk("len0_busy", busy, 0);
    tick();
    req[2] = 1'b0;
    wait_acks(1, "len0_b");
    tick();
    req = '0;
    wait_idle("len0");
    if (ack_log_id.size() >= lb + 2) begin
      chk("len0_first_id", ack_log_id[lb], 2);
      chk("len0_next_id", ack_log_id[lb+1], 3);
      chk("len0_next_gap", ack_log_cyc[lb+1] - ack_log_cyc[lb], 1);
    end

    // single-burst vector table
    for (int i = 0; i < 7; i++) begin
      tick();
      p0 = pix_cnt; l0 = last_cnt; b0 = busy_cnt;
      op_log.delete();
      set_req(tbl[i].id, tbl[i].addr, tbl[i].len);
      wait_acks(1, "tbl");
      chk("tbl_ack", last_ack, tbl[i].exp_ack);
      tick();
      req = '0;
      wait_idle("tbl");
      chk("tbl_npix", pix_cnt - p0, tbl[i].exp_npix);
      chk("tbl_nlast", last_cnt - l0, (tbl[i].exp_npix != 0) ? 1 : 0);
      chk("tbl_busy_cycles", busy_cnt - b0, tbl[i].len);
      if (tbl[i].exp_npix != 0) begin
        chk("tbl_first_addr", burst_first, tbl[i].exp_first);
        chk("tbl_last_addr", burst_last, tbl[i].exp_last);
      end
      if (tbl[i].addr == 500 && op_log.size() >= 2) begin
        chk("chroma_key_word", op_log[0][49:25], {24'h00FF00, KEY_OPAQUE});
        chk("chroma_other_word", op_log[1][49:25], {24'hFF512F, 1'b1});
      end
    end

    // reset mid-burst at k=2 of 6
    tick();
    set_req(1, 300, 6);
    wait_acks(1, "midrst");
    tick();
    req = '0;
    repeat (3) @(negedge Clk);
    #1;
    chk("midrst_k2_addr", rom_addr, 302);
    Reset_n = 1'b0;
    #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pix", {pix_valid, pix_data, pix_id, pix_last, pix_opaque}, 0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    p0 = pix_cnt;
    repeat (6) tick();
    chk("midrst_no_stray", pix_cnt - p0, 0);
    // rr pointer back at 0: with req[1] and req[3], requester 1 wins
    set_req(1, 20, 1);
    set_req(3, 30, 1);
    wait_acks(1, "rr_restart");
    chk("rr_restart_ack", last_ack, 4'b0010);
    tick();
    req[1] = 1'b0;
    wait_acks(1, "rr_restart_b");
    chk("rr_restart_second", last_ack, 4'b1000);
    tick();
    req = '0;
    wait_idle("rr_restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
